// File: rtl/clk_div_glitchfree_pkg.sv
// Shared types and constants for the glitch-free integer clock divider.
package clk_div_glitchfree_pkg;

  // Divider operating state
  typedef enum logic {
    ST_BYPASS = 1'b0,
    ST_DIVIDE = 1'b1
  } state_e;

  // Smallest ratio that actually divides; anything below passes the reference through
  localparam int unsigned MIN_RATIO = 2;

  // High-phase length of one divided period for a ratio. Evaluated in 32 bits so that
  // the round-up case cannot overflow at the maximum ratio of the counter width.
  function automatic int unsigned hi_len(input int unsigned ratio, input bit round_up);
    return round_up ? ((ratio + 1) >> 1) : (ratio >> 1);
  endfunction

endpackage

// File: rtl/clk_div_glitchfree_div_period_cnt.sv
// Period counter for the divider: counts up from zero, clears on request, and flags
// the last count of the period (ratio-1).
module div_period_cnt #(
  parameter int DIV_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [DIV_W-1:0] i_ratio,
  output logic [DIV_W-1:0] o_cnt_nxt,
  output logic             o_last
);

  logic [DIV_W-1:0] r_cnt;

  // Count register: clear has priority over increment, never wraps past ratio-1
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

  // Last-count flag and the value the counter moves to when it increments
  always_comb begin
    o_last    = (r_cnt == (i_ratio - DIV_W'(1)));
    o_cnt_nxt = r_cnt + DIV_W'(1);
  end

endmodule

// File: rtl/clk_div_glitchfree.sv
// Glitch-free runtime-programmable integer clock divider.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_BYPASS  | o_div_clk follows i_ref_clk; go is sampled every edge
//   ST_DIVIDE  | o_div_clk driven from r_div_q; go sampled only at last count
//
// Ratio/enable are only looked at on a period boundary, so a period in flight always
// finishes with its original high and low phases. Entry to DIVIDE happens on a ref
// rising edge (ref was low, div_q becomes high) and exit happens on a ref rising edge
// after the low last count, so the output mux never produces a runt pulse.
module clk_div_glitchfree
  import clk_div_glitchfree_pkg::*;
#(
  parameter int DIV_W       = 5,
  parameter int HI_ROUND_UP = 0
) (
  input  logic             i_ref_clk,
  input  logic             i_rst,
  input  logic             i_clk_en,
  input  logic [DIV_W-1:0] i_div_ratio,
  output logic             o_div_clk,
  output logic             o_tick,
  output logic             o_active,
  output logic [DIV_W-1:0] o_ratio
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [DIV_W-1:0] r_act_ratio;
  logic             r_div_q;
  logic             r_tick;

  logic             w_go;
  logic             w_last;
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [DIV_W-1:0] w_hi_len;

  // Request to divide, and the high-phase length of the ratio in effect
  always_comb begin
    w_go     = i_clk_en && (i_div_ratio >= DIV_W'(MIN_RATIO));
    w_hi_len = DIV_W'(hi_len(32'(r_act_ratio), (HI_ROUND_UP != 0)));
  end

  // Counter held at zero in bypass, restarted at every period boundary
  always_comb begin
    w_cnt_clr = (r_state == ST_BYPASS) || w_last;
    w_cnt_inc = (r_state == ST_DIVIDE);
  end

  div_period_cnt #(
    .DIV_W (DIV_W)
  ) u_period_cnt (
    .i_clk     (i_ref_clk),
    .i_rst     (i_rst),
    .i_clr     (w_cnt_clr),
    .i_inc     (w_cnt_inc),
    .i_ratio   (r_act_ratio),
    .o_cnt_nxt (w_cnt_nxt),
    .o_last    (w_last)
  );

  // State register
  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      r_state <= ST_BYPASS;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: leave bypass on go, leave divide only at the last count
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BYPASS: if (w_go) w_state_nxt = ST_DIVIDE;
      ST_DIVIDE: if (w_last && !w_go) w_state_nxt = ST_BYPASS;
      default:   w_state_nxt = ST_BYPASS;
    endcase
  end

  // Ratio latch, registered divided level and period-start strobe
  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      r_act_ratio <= '0;
      r_div_q     <= 1'b0;
      r_tick      <= 1'b0;
    end else if ((r_state == ST_BYPASS) || w_last) begin
      if (w_go) begin
        r_act_ratio <= i_div_ratio;
        r_div_q     <= 1'b1;
        r_tick      <= 1'b1;
      end else begin
        r_act_ratio <= '0;
        r_div_q     <= 1'b0;
        r_tick      <= 1'b0;
      end
    end else begin
      r_div_q <= (w_cnt_nxt < w_hi_len);
      r_tick  <= 1'b0;
    end
  end

  // Output mux: reference passes straight through while bypassing
  always_comb begin
    o_div_clk = (r_state == ST_DIVIDE) ? r_div_q : i_ref_clk;
    o_active  = (r_state == ST_DIVIDE);
    o_tick    = r_tick;
    o_ratio   = r_act_ratio;
  end

endmodule

// File: tb/tb_clk_div_glitchfree.sv
// Bench for clk_div_glitchfree: three instances (5-bit floor duty, 5-bit ceil duty,
// 8-bit floor duty) share reset/enable and are compared against a period-level model.
module tb_clk_div_glitchfree;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [4:0] r5;
  logic [7:0] r8;

  always #5 clk = ~clk;

  logic       a_div, a_tick, a_act;
  logic [4:0] a_rat;
  logic       b_div, b_tick, b_act;
  logic [4:0] b_rat;
  logic       c_div, c_tick, c_act;
  logic [7:0] c_rat;

  clk_div_glitchfree #(.DIV_W(5), .HI_ROUND_UP(0)) u_dut_a (
    .i_ref_clk(clk), .i_rst(rst), .i_clk_en(en), .i_div_ratio(r5),
    .o_div_clk(a_div), .o_tick(a_tick), .o_active(a_act), .o_ratio(a_rat));

  clk_div_glitchfree #(.DIV_W(5), .HI_ROUND_UP(1)) u_dut_b (
    .i_ref_clk(clk), .i_rst(rst), .i_clk_en(en), .i_div_ratio(r5),
    .o_div_clk(b_div), .o_tick(b_tick), .o_active(b_act), .o_ratio(b_rat));

  clk_div_glitchfree #(.DIV_W(8), .HI_ROUND_UP(0)) u_dut_c (
    .i_ref_clk(clk), .i_rst(rst), .i_clk_en(en), .i_div_ratio(r8),
    .o_div_clk(c_div), .o_tick(c_tick), .o_active(c_act), .o_ratio(c_rat));

  logic       ob_div[3];
  logic       ob_tick[3];
  logic       ob_act[3];
  logic [7:0] ob_rat[3];

  assign ob_div[0] = a_div;  assign ob_tick[0] = a_tick;  assign ob_act[0] = a_act;
  assign ob_div[1] = b_div;  assign ob_tick[1] = b_tick;  assign ob_act[1] = b_act;
  assign ob_div[2] = c_div;  assign ob_tick[2] = c_tick;  assign ob_act[2] = c_act;
  assign ob_rat[0] = {3'b000, a_rat};
  assign ob_rat[1] = {3'b000, b_rat};
  assign ob_rat[2] = c_rat;

  int n_chk = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // Model: position within the current divided period (-1 = bypass) and its ratio
  int m_pos[3] = '{-1, -1, -1};
  int m_n[3]   = '{0, 0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int hi(input int i, input int n);
    return (i == 1) ? (n + 1) / 2 : n / 2;
  endfunction

  function automatic int req(input int i);
    return (i == 2) ? int'(r8) : int'(r5);
  endfunction

  function automatic int exp_level(input int i, input int ref_lvl);
    return (m_pos[i] >= 0) ? ((m_pos[i] < hi(i, m_n[i])) ? 1 : 0) : ref_lvl;
  endfunction

  // Advance the model by one ref edge using the inputs present at that edge
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      bit go;
      go = en && (req(i) >= 2);
      if (rst) begin
        m_pos[i] = -1;
        m_n[i]   = 0;
      end else if (m_pos[i] >= 0 && m_pos[i] + 1 < m_n[i]) begin
        m_pos[i] = m_pos[i] + 1;
      end else if (go) begin
        m_pos[i] = 0;
        m_n[i]   = req(i);
      end else begin
        m_pos[i] = -1;
        m_n[i]   = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    chk_on = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("div_hi%0d", i),  32'(ob_div[i]),  32'(exp_level(i, 1)));
      chk($sformatf("tick%0d", i),    32'(ob_tick[i]), 32'(m_pos[i] == 0));
      chk($sformatf("active%0d", i),  32'(ob_act[i]),  32'(m_pos[i] >= 0));
      chk($sformatf("ratio%0d", i),   32'(ob_rat[i]),  32'(m_n[i]));
    end
  endtask

  task automatic wait_pos(input int i, input int p);
    int k = 0;
    while (m_pos[i] != p && k < 600) begin
      step();
      k++;
    end
    chk($sformatf("wait_pos%0d", i), 32'(m_pos[i]), 32'(p));
  endtask

  // Low half of each ref cycle: bypass output must be low, divided output holds level
  always @(negedge clk) begin
    if (chk_on) begin
      #1;
      for (int i = 0; i < 3; i++)
        chk($sformatf("div_lo%0d", i), 32'(ob_div[i]), 32'(exp_level(i, 0)));
    end
  end

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    r5  = 5'd0;
    r8  = 8'd0;
    step();
    step();

    // Basic divide by 4 on the 5-bit parts, 255 on the 8-bit part
    rst = 1'b0;
    en  = 1'b1;
    r5  = 5'd4;
    r8  = 8'd255;
    wait_pos(2, 100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    r8  = 8'd10;
    chk("rst_active_c", 32'(c_act), 32'd0);
    chk("rst_ratio_c",  32'(c_rat), 32'd0);

    // Ratio change mid-period, odd ratio, then disable mid-period
    repeat (10) step();
    wait_pos(0, 1);
    r5 = 5'd6;
    repeat (16) step();
    r5 = 5'd5;
    repeat (20) step();
    r5 = 5'd8;
    repeat (12) step();
    wait_pos(0, 3);
    en = 1'b0;
    repeat (14) step();
    en = 1'b1;
    r5 = 5'd1;
    repeat (10) step();
    r5 = 5'd0;
    repeat (10) step();

    // Randomised traffic
    repeat (3000) begin
      step();
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 5) == 0)
        r5 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 1)) : 5'($urandom_range(2, 31));
      if ($urandom_range(0, 5) == 0)
        r8 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
    end
    step();

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
